// File: rtl/pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_streamer
// Description : Holds an IMG_H x IMG_W one-bit frame buffer that is loaded
//               row by row while idle, and streams it out one pixel per cycle
//               (row-major, column 0 first) when start is accepted. The
//               stream feeds a downstream max_pooling block.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset; clears buffer and outputs
//   wr_en        in   row-write strobe (honoured only while idle)
//   wr_row       in   row index for the write; rows >= IMG_H are ignored
//   wr_data      in   row pixels, bit j = column j
//   start        in   stream request (idle only, and only with wr_en low)
//   stall_in     in   [PIXEL_STREAMER_STALL_EN only] hold the stream a cycle
//   pixel_out    out  streamed pixel
//   valid_out    out  pixel_out valid this cycle
//   frame_first  out  pixel (0,0)
//   frame_last   out  pixel (IMG_H-1, IMG_W-1)
//   busy         out  frame in progress
//   done         out  one-cycle end-of-frame pulse
// Optional feature macro: PIXEL_STREAMER_STALL_EN
// ============================================================================
module pixel_streamer #(
    parameter int IMG_W = 5,
    parameter int IMG_H = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] wr_row,
    input  logic [IMG_W-1:0]                    wr_data,
    input  logic                                start,
`ifdef PIXEL_STREAMER_STALL_EN
    input  logic                                stall_in,
`endif
    output logic                                pixel_out,
    output logic                                valid_out,
    output logic                                frame_first,
    output logic                                frame_last,
    output logic                                busy,
    output logic                                done
);

    localparam int C_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int C_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(IMG_H - 1);
    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(IMG_W - 1);
    // One extra bit so IMG_H itself is representable for the range check.
    localparam logic [C_ROW_W:0]   C_ROW_LIM  = (C_ROW_W + 1)'(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IMG_W-1:0]     buf_q [IMG_H];
    logic [IMG_W-1:0]     buf_d [IMG_H];
    logic [C_ROW_W-1:0]   row_q, row_d;
    logic [C_COL_W-1:0]   col_q, col_d;
    logic                 pixel_q, pixel_d;
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic                 last_q,  last_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic                 w_stall;
    logic                 w_row_ok;

`ifdef PIXEL_STREAMER_STALL_EN
    assign w_stall = stall_in;
`else
    assign w_stall = 1'b0;
`endif

    assign w_row_ok = ({1'b0, wr_row} < C_ROW_LIM);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        pixel_d = 1'b0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write always wins over start in the same cycle.
                if (wr_en) begin
                    if (w_row_ok) begin
                        buf_d[wr_row] = wr_data;
                    end
                end else if (start) begin
                    state_d = ST_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            ST_STREAM: begin
                // A stall holds the pixel index and emits an invalid cycle.
                if (!w_stall) begin
                    pixel_d = buf_q[row_q][col_q];
                    valid_d = 1'b1;
                    first_d = (row_q == '0) && (col_q == '0);
                    last_d  = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);
                    if (col_q == C_COL_LAST) begin
                        col_d = '0;
                        if (row_q == C_ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + C_ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + C_COL_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // The last pixel is on the output during this state; done
                // follows one cycle later as the FSM returns to idle.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int r = 0; r < IMG_H; r++) begin
                buf_q[r] <= '0;
            end
            row_q   <= '0;
            col_q   <= '0;
            pixel_q <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pixel_out   = pixel_q;
    assign valid_out   = valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pixel_streamer
// Description : Self-checking bench for pixel_streamer. A frame model (array
//               of rows) is updated by the write rules and turned into the
//               expected row-major pixel list for every stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_streamer;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [W-1:0]  wr_data;
    logic          start;
`ifdef PIXEL_STREAMER_STALL_EN
    logic          stall_in_tb;
`endif
    logic          pixel_out, valid_out, frame_first, frame_last, busy, done;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] model [H];

    always #5 clk = ~clk;

    pixel_streamer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .start       (start),
`ifdef PIXEL_STREAMER_STALL_EN
        .stall_in    (stall_in_tb),
`endif
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .frame_first (frame_first),
        .frame_last  (frame_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pixel"}, pixel_out,   0);
        chk({tag, " valid"}, valid_out,   0);
        chk({tag, " first"}, frame_first, 0);
        chk({tag, " last"},  frame_last,  0);
        chk({tag, " busy"},  busy,        0);
        chk({tag, " done"},  done,        0);
    endtask

    // Row write while idle; the model only takes rows inside the frame.
    task automatic do_write(input int row, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_row  = RW'(row);
        wr_data = data;
        tick;
        wr_en   = 1'b0;
        if (row < H) model[row] = data;
    endtask

    // Issues start in the current cycle and checks the whole frame up to the
    // done pulse. Returns in the done cycle so a caller may start again.
    task automatic run_stream(input string tag, input int stall_start,
                              input int stall_len, input bit noise);
        logic exp_px [N];
        int   k;
        int   j;
        int   cyc;
        bit   st;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_px[r*W + c] = model[r][c];
        k   = 0;
        j   = 0;
        wr_en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        chk({tag, " busy_rise"}, busy, 1);
        chk({tag, " no_valid_T1"}, valid_out, 0);
        while (k < N && cyc < N + 40) begin
            st = (stall_len > 0) && (j >= stall_start) && (j < stall_start + stall_len);
`ifdef PIXEL_STREAMER_STALL_EN
            stall_in_tb = st;
`endif
            if (noise) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_row  = RW'($urandom_range(0, 7));
                wr_data = W'($urandom);
                start   = 1'($urandom_range(0, 1));
            end
            tick;
            cyc++;
            j++;
            if (st) begin
                chk({tag, " stall_valid"}, valid_out, 0);
                chk({tag, " stall_pixel"}, pixel_out, 0);
                chk({tag, " stall_busy"},  busy, 1);
            end else begin
                chk({tag, " valid"}, valid_out, 1);
                chk({tag, " pixel"}, pixel_out, exp_px[k]);
                chk({tag, " first"}, frame_first, (k == 0));
                chk({tag, " last"},  frame_last,  (k == N - 1));
                chk({tag, " busy"},  busy, 1);
                chk({tag, " done_early"}, done, 0);
                k++;
            end
        end
        chk({tag, " pixel_count"}, k, N);
`ifdef PIXEL_STREAMER_STALL_EN
        stall_in_tb = 1'b0;
`endif
        wr_en = 1'b0;
        start = 1'b0;
        tick;
        cyc++;
        chk({tag, " done"},       done, 1);
        chk({tag, " busy_fall"},  busy, 0);
        chk({tag, " done_valid"}, valid_out, 0);
        chk({tag, " done_last"},  frame_last, 0);
        chk({tag, " done_cycle"}, cyc, N + 2 + stall_len);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        start   = 1'b0;
`ifdef PIXEL_STREAMER_STALL_EN
        stall_in_tb = 1'b0;
`endif
        for (int r = 0; r < H; r++) model[r] = '0;

        // Reset state
        tick;
        tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick;

        // Checkerboard frame, then a back-to-back restream of it
        do_write(0, 5'h0A);
        do_write(1, 5'h15);
        do_write(2, 5'h0A);
        do_write(3, 5'h15);
        do_write(4, 5'h0A);
        run_stream("checker", 0, 0, 1'b0);
        run_stream("b2b", 0, 0, 1'b0);
        tick;
        chk("done_one_cycle", done, 0);

        // Out-of-range rows must not touch the frame
        do_write(7, 5'h1F);
        do_write(5, 5'h1F);
        run_stream("bad_row", 0, 0, 1'b0);
        tick;

        // start together with wr_en: write lands, no stream begins
        wr_en   = 1'b1;
        start   = 1'b1;
        wr_row  = 3'd2;
        wr_data = 5'h1B;
        model[2] = 5'h1B;
        tick;
        wr_en = 1'b0;
        start = 1'b0;
        chk("start_wr_busy", busy, 0);
        tick;
        chk("start_wr_busy2", busy, 0);
        chk("start_wr_valid", valid_out, 0);
        run_stream("after_start_wr", 0, 0, 1'b0);
        tick;

        // Random frames; noise writes/starts while busy must be ignored,
        // and the following quiet stream shows the frame persisted.
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < H; r++) do_write(r, W'($urandom));
            for (int m = 0; m < 3; m++) do_write($urandom_range(0, 7), W'($urandom));
            run_stream("rand_noise", 0, 0, 1'b1);
            tick;
            run_stream("rand_repeat", 0, 0, 1'b0);
            tick;
        end

`ifdef PIXEL_STREAMER_STALL_EN
        run_stream("stall", 10, 3, 1'b0);
        tick;
`endif

        // Reset while pixel 12 is on the output
        for (int r = 0; r < H; r++) do_write(r, 5'h1F);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick;
        chk("pre_rst_valid", valid_out, 1);
        chk("pre_rst_pixel", pixel_out, 1);
        rst_n = 1'b0;
        tick;
        chk_all_zero("mid_rst");
        rst_n = 1'b1;
        for (int r = 0; r < H; r++) model[r] = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_rst_done", done, 0);
            chk("post_rst_last", frame_last, 0);
            chk("post_rst_valid", valid_out, 0);
        end
        run_stream("post_rst_zero", 0, 0, 1'b0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
